uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter UART_CLKS_PER_BIT, default 868, giving in_clk cycles per serial bit (115200 baud at 100 MHz); legal range is 4 and above.
REQ-002 SHALL have port in_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 SHALL have port in_rst_n, input, 1 bit, reset; asynchronous and active-low.
REQ-004 SHALL have port in_rx, input, 1 bit, asynchronous serial line; idle high.
REQ-005 SHALL have port rx_trig, input, 1 bit, one-cycle arm pulse from the protocol decoder requesting the next byte.
REQ-006 SHALL have port in_err_clr, input, 1 bit, clears the sticky error flags.
REQ-007 SHALL have port data_rx, output, 8 bits, delivered byte; held stable until the next delivery.
REQ-008 SHALL have port rx_done, output, 1 bit, one-cycle pulse marking data_rx as valid.
REQ-009 SHALL have ports out_rx_frame_err, out_rx_overrun and out_rx_parity_err, each an output of 1 bit and each a sticky error flag.

Function
REQ-010 SHALL pass in_rx through a 2-flop synchroniser that resets to 1; all line decisions use the synchronised value.
REQ-011 SHALL use FSM states IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE.
REQ-012 In IDLE, a synchronised 0 SHALL move the FSM to START and load the bit counter.
REQ-013 In START, the line SHALL be sampled after UART_CLKS_PER_BIT/2 cycles (integer divide); a sample of 1 is a false start and returns to IDLE without error, and a sample of 0 moves to DATA.
REQ-014 In DATA, 8 bits SHALL be sampled, one every UART_CLKS_PER_BIT cycles, LSB first, into a shift register.
REQ-015 In STOP, the line SHALL be sampled after one bit period; a 1 writes the byte to the holding buffer and goes to IDLE.
REQ-016 A STOP sample of 0 SHALL set out_rx_frame_err, discard the byte and go to WAIT_IDLE; WAIT_IDLE returns to IDLE at the first synchronised 1.
REQ-017 An armed flag SHALL be 1 after reset, cleared on each delivery and set by rx_trig.
REQ-018 Delivery: in any cycle where the buffer is valid and armed is 1, the next edge SHALL load data_rx from the buffer, pulse rx_done, clear the buffer-valid bit and clear armed.
REQ-019 Latency SHALL be 1 cycle from the buffer write to rx_done when armed, and 1 cycle from rx_trig to rx_done when a byte is already buffered.
REQ-020 A byte completing while the buffer is still valid SHALL be dropped, the old byte kept, and out_rx_overrun set.
REQ-021 rx_trig coinciding with a delivery SHALL leave armed set; rx_trig while already armed has no effect.
REQ-022 A buffer write and a delivery in the same cycle SHALL not occur; a buffer write sets valid only, so delivery follows one cycle later.
REQ-023 in_err_clr SHALL clear all sticky flags; an error event in the same cycle wins and the flag stays set.
REQ-024 Reception SHALL continue regardless of armed; the FSM is never stalled by the consumer.

Reset
REQ-025 In-rst_n low SHALL immediately force: state IDLE, synchroniser 1/1, counters 0, buffer invalid, armed 1, data_rx 0x00, rx_done 0, all error flags 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, reception restarts only on a fresh falling edge seen in IDLE.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, a PARITY state SHALL follow DATA, sampling one even-parity bit.
REQ-028 With the macro, a parity mismatch SHALL set out_rx_parity_err and discard the byte, and STOP framing still applies.
REQ-029 Without the macro, no PARITY state SHALL exist, the frame is 8N1, and out_rx_parity_err is tied 0.

Verification (UART_CLKS_PER_BIT=16)
REQ-030 Reset release, then frame 0xA5 -> rx_done pulses once, 1 cycle after the buffer write, with data_rx=0xA5.
REQ-031 Frames 0x01 then 0x02 with no rx_trig -> the first is delivered; 0x02 is held without rx_done; rx_trig -> rx_done with 0x02 on the next cycle.
REQ-032 Three frames 0x10/0x20/0x30 with no rx_trig after the first -> 0x10 delivered, 0x20 buffered, 0x30 dropped and out_rx_overrun=1; in_err_clr -> 0.
REQ-033 Frame 0x55 with stop bit 0, then 40 cycles low, then idle, then 0x66 -> out_rx_frame_err=1, no rx_done for 0x55, and 0x66 delivered correctly.
REQ-034 A 4-cycle low glitch on the idle line -> false start, no rx_done and no error flag; in_rst_n pulsed low during the DATA bits of a frame -> no delivery and all outputs at reset values.
REQ-035 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> delivered; 0x07 with parity bit 0 -> out_rx_parity_err=1 and no rx_done.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver with a one-byte holding buffer and an arm/deliver handshake toward the protocol decoder.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx_ctrl #(
    parameter int unsigned UART_CLKS_PER_BIT = 868
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_rx,
    input  logic       rx_trig,
    input  logic       in_err_clr,
    output logic [7:0] data_rx,
    output logic       rx_done,
    output logic       out_rx_frame_err,
    output logic       out_rx_overrun,
    output logic       out_rx_parity_err
);

    localparam int unsigned CNT_W    = $clog2(UART_CLKS_PER_BIT);
    localparam int unsigned HALF_BIT = UART_CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(UART_CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state, state_nxt;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             byte_ok;
    logic             frame_err_ev;
    logic             buf_valid;
    logic [7:0]       buf_data;
    logic             armed;
    logic             deliver;
`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_nxt;
    logic             par_err_ev;
`endif

    // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= in_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bit-timing logic; all line samples use rx_sync.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_W'(1);
        bit_nxt      = bit_cnt;
        shift_nxt    = shift;
        byte_ok      = 1'b0;
        frame_err_ev = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt  = par_bad;
        par_err_ev   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_sync) begin
                    state_nxt = START;
                    bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_nxt = 1'b0;
`endif
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_sync, shift[7:1]};
                    bit_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = STOP;
                    if ((^shift) != rx_sync) begin
                        par_bad_nxt = 1'b1;
                        par_err_ev  = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_sync) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        byte_ok   = !par_bad;
`else
                        byte_ok   = 1'b1;
`endif
                    end else begin
                        state_nxt    = WAIT_IDLE;
                        frame_err_ev = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_nxt = '0;
                if (rx_sync) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nxt;
`endif
        end
    end

    // A trigger in the same cycle counts as armed; it is consumed unless armed was already set.
    assign deliver = buf_valid && (armed || rx_trig);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            armed     <= 1'b1;
            data_rx   <= '0;
            rx_done   <= 1'b0;
        end else begin
            rx_done <= deliver;
            if (deliver) begin
                data_rx   <= buf_data;
                buf_valid <= 1'b0;
                armed     <= armed && rx_trig;
            end else begin
                if (rx_trig) begin
                    armed <= 1'b1;
                end
                if (byte_ok && !buf_valid) begin
                    buf_valid <= 1'b1;
                    buf_data  <= shift;
                end
            end
        end
    end

    // Sticky flags: a same-cycle error event wins over the clear.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_rx_frame_err <= 1'b0;
            out_rx_overrun   <= 1'b0;
        end else begin
            if (frame_err_ev) begin
                out_rx_frame_err <= 1'b1;
            end else if (in_err_clr) begin
                out_rx_frame_err <= 1'b0;
            end
            if (byte_ok && buf_valid) begin
                out_rx_overrun <= 1'b1;
            end else if (in_err_clr) begin
                out_rx_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_rx_parity_err <= 1'b0;
        end else if (par_err_ev) begin
            out_rx_parity_err <= 1'b1;
        end else if (in_err_clr) begin
            out_rx_parity_err <= 1'b0;
        end
    end
`else
    assign out_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and random frames checked against a transaction-level model of the buffer/arm handshake.
module tb_uart_rx_ctrl;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NPAR = 1;
`else
    localparam int unsigned NPAR = 0;
`endif
    // Falling edge -> 2 sync flops -> IDLE detect -> half bit -> data (+parity) -> stop -> delivery.
    localparam int unsigned LAT = 3 + CPB / 2 + (9 + NPAR) * CPB + 1;

    logic       in_clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic       in_rx = 1'b1;
    logic       rx_trig = 1'b0;
    logic       in_err_clr = 1'b0;
    logic [7:0] data_rx;
    logic       rx_done;
    logic       out_rx_frame_err;
    logic       out_rx_overrun;
    logic       out_rx_parity_err;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;

    logic [7:0]  obs_q[$];
    int unsigned obs_cyc_q[$];

    logic [7:0] exp_q[$];
    logic       m_armed, m_buf_v, m_ovr, m_fe, m_pe;
    logic [7:0] m_buf;

    uart_rx_ctrl #(.UART_CLKS_PER_BIT(CPB)) dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .in_rx            (in_rx),
        .rx_trig          (rx_trig),
        .in_err_clr       (in_err_clr),
        .data_rx          (data_rx),
        .rx_done          (rx_done),
        .out_rx_frame_err (out_rx_frame_err),
        .out_rx_overrun   (out_rx_overrun),
        .out_rx_parity_err(out_rx_parity_err)
    );

    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) cyc <= cyc + 1;

    always @(negedge in_clk) begin
        if (rx_done) begin
            obs_q.push_back(data_rx);
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b1; m_buf_v = 1'b0; m_buf = 8'h00;
        m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic model_good(input logic [7:0] b);
        if (m_buf_v) m_ovr = 1'b1;
        else begin
            m_buf_v = 1'b1;
            m_buf = b;
        end
        if (m_buf_v && m_armed) begin
            exp_q.push_back(m_buf);
            m_buf_v = 1'b0;
            m_armed = 1'b0;
        end
    endtask

    task automatic model_trig();
        if (m_buf_v) begin
            exp_q.push_back(m_buf);
            m_buf_v = 1'b0;
        end else begin
            m_armed = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge in_clk);
        in_rx = 1'b1;
        in_rst_n = 1'b0;
        repeat (3) @(negedge in_clk);
        in_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic pulse_trig();
        @(negedge in_clk);
        rx_trig = 1'b1;
        @(negedge in_clk);
        rx_trig = 1'b0;
        model_trig();
    endtask

    // Drives start, data LSB first, optional parity, stop; leaves the line at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, output int unsigned t0);
        logic [7:0] d;
        d = b;
        @(negedge in_clk);
        in_rx = 1'b0;
        t0 = cyc;
        repeat (CPB) @(negedge in_clk);
        for (int i = 0; i < 8; i++) begin
            in_rx = d[i];
            repeat (CPB) @(negedge in_clk);
        end
        if (NPAR != 0) begin
            in_rx = par;
            repeat (CPB) @(negedge in_clk);
        end
        in_rx = stop;
        repeat (CPB) @(negedge in_clk);
    endtask

    task automatic send_good(input logic [7:0] b, output int unsigned t0);
        send_frame(b, ^b, 1'b1, t0);
        in_rx = 1'b1;
        repeat (2 * CPB) @(negedge in_clk);
        model_good(b);
    endtask

    task automatic check_deliveries(input string tag);
        int unsigned n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < int'(n); i++) check({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovr"}, 32'(out_rx_overrun), 32'(m_ovr));
        check({tag, "_fe"}, 32'(out_rx_frame_err), 32'(m_fe));
        check({tag, "_pe"}, 32'(out_rx_parity_err), 32'(m_pe));
    endtask

    task automatic clear_errors();
        @(negedge in_clk);
        in_err_clr = 1'b1;
        @(negedge in_clk);
        in_err_clr = 1'b0;
        m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    endtask

    initial begin
        int unsigned t0;
        int unsigned t_lat;
        logic [7:0] rb;
        model_reset();
        repeat (3) @(negedge in_clk);
        check("rst_data", 32'(data_rx), 32'h00);
        check("rst_done", 32'(rx_done), 32'h0);
        check_flags("rst");
        in_rst_n = 1'b1;
        repeat (4) @(negedge in_clk);

        // Single frame: delivery and latency
        send_good(8'hA5, t0);
        t_lat = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - t0 : 0;
        check("a5_latency", t_lat, LAT);
        check_deliveries("a5");
        check("a5_data_held", 32'(data_rx), 32'hA5);

        // Second byte held until trig, then delivered one cycle later
        do_reset();
        send_good(8'h01, t0);
        send_good(8'h02, t0);
        check_deliveries("hold");
        check("hold_no_done", 32'(rx_done), 32'h0);
        @(negedge in_clk);
        rx_trig = 1'b1;
        @(negedge in_clk);
        rx_trig = 1'b0;
        model_trig();
        check("trig_done", 32'(rx_done), 32'h1);
        check("trig_data", 32'(data_rx), 32'h02);
        repeat (2) @(negedge in_clk);
        check_deliveries("trig");

        // Overrun: third byte dropped, buffered byte kept
        do_reset();
        send_good(8'h10, t0);
        send_good(8'h20, t0);
        send_good(8'h30, t0);
        check_flags("ovr");
        clear_errors();
        check_flags("ovr_clr");
        pulse_trig();
        repeat (2) @(negedge in_clk);
        check_deliveries("ovr");

        // Framing error, long break, then a good frame
        do_reset();
        send_frame(8'h55, ^8'h55, 1'b0, t0);
        repeat (40) @(negedge in_clk);
        in_rx = 1'b1;
        repeat (3 * CPB) @(negedge in_clk);
        m_fe = 1'b1;
        check_flags("fe");
        send_good(8'h66, t0);
        check_deliveries("fe");
        clear_errors();
        check_flags("fe_clr");

        // Short glitch is a false start
        do_reset();
        @(negedge in_clk);
        in_rx = 1'b0;
        repeat (4) @(negedge in_clk);
        in_rx = 1'b1;
        repeat (3 * CPB) @(negedge in_clk);
        check_deliveries("glitch");
        check_flags("glitch");
        send_good(8'h81, t0);
        check_deliveries("after_glitch");

        // Reset in the middle of the data bits
        do_reset();
        send_good(8'hC3, t0);
        send_good(8'h3C, t0);
        check_deliveries("pre_rst");
        @(negedge in_clk);
        in_rx = 1'b0;
        repeat (CPB) @(negedge in_clk);
        in_rx = 1'b1;
        repeat (2 * CPB) @(negedge in_clk);
        in_rx = 1'b0;
        repeat (CPB / 2) @(negedge in_clk);
        in_rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_data", 32'(data_rx), 32'h00);
        check("mid_rst_done", 32'(rx_done), 32'h0);
        check_flags("mid_rst");
        @(negedge in_clk);
        in_rx = 1'b1;
        repeat (2) @(negedge in_clk);
        in_rst_n = 1'b1;
        repeat (12 * CPB) @(negedge in_clk);
        check_deliveries("mid_rst");
        send_good(8'h5A, t0);
        check_deliveries("post_rst");

        // Random bytes with random arming
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 1) == 1) pulse_trig();
            send_good(rb, t0);
        end
        pulse_trig();
        repeat (2) @(negedge in_clk);
        check_deliveries("rand");
        check_flags("rand");

`ifdef UART_RX_PARITY_EN
        do_reset();
        send_good(8'h07, t0);
        check_deliveries("par_ok");
        pulse_trig();
        send_frame(8'h07, 1'b0, 1'b1, t0);
        in_rx = 1'b1;
        repeat (2 * CPB) @(negedge in_clk);
        m_pe = 1'b1;
        check_deliveries("par_bad");
        check_flags("par_bad");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
